// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first, enable-gated shifting.
// Define PARITY_EN to append an even-parity bit after each word.
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Load,
    input  logic [WIDTH-1:0] Pin,
    input  logic             En,
    output logic             Ready,
    output logic             Dout,
    output logic             Frame,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dout_q, dout_d;
    logic done_q, done_d;
`ifdef PARITY_EN
    logic par_q, par_d;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                dout_d = 1'b0;
                if (Load) begin
                    sr_d    = Pin >> 1;
                    dout_d  = Pin[0];
                    cnt_d   = '0;
`ifdef PARITY_EN
                    par_d   = ^Pin;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (En && cnt_q != LAST) begin
                    dout_d = sr_q[0];
                    sr_d   = sr_q >> 1;
                    cnt_d  = cnt_q + 1'b1;
                end else if (En) begin
`ifdef PARITY_EN
                    dout_d  = par_q;
                    state_d = PARITY;
`else
                    dout_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (En) begin
                    dout_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign Ready = (state_q == IDLE);
    assign Frame = (state_q != IDLE);
    assign Dout  = dout_q;
    assign Done  = done_q;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed self-checking bench for piso_tx (WIDTH=8).
module tb_piso_tx;
    logic       CLK, RST_N, Load, En, Ready, Dout, Frame, Done;
    logic [7:0] Pin;
    logic [7:0] w;
    int n_cmp = 0;
    int n_err = 0;
    int frame_cycles = 0;

    piso_tx #(.WIDTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .Load(Load), .Pin(Pin), .En(En),
        .Ready(Ready), .Dout(Dout), .Frame(Frame), .Done(Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
        if (Frame) frame_cycles++;
    endtask

    // Parity bit (when compiled in) followed by the single Done/IDLE cycle.
    task automatic end_frame(input string tag, input logic par);
`ifdef PARITY_EN
        step;
        chk({tag, "_parity"}, Dout, par);
        chk({tag, "_parity_frame"}, Frame, 1'b1);
        chk({tag, "_parity_nodone"}, Done, 1'b0);
`endif
        step;
        chk({tag, "_done"}, Done, 1'b1);
        chk({tag, "_done_ready"}, Ready, 1'b1);
        chk({tag, "_done_dout"}, Dout, 1'b0);
        chk({tag, "_done_frame"}, Frame, 1'b0);
    endtask

    initial begin
        RST_N = 1'b0; Load = 1'b0; En = 1'b0; Pin = 8'h00;
        #1;
        chk("rst_ready", Ready, 1'b1);
        chk("rst_dout", Dout, 1'b0);
        chk("rst_frame", Frame, 1'b0);
        chk("rst_done", Done, 1'b0);
        #11 RST_N = 1'b1;

        // Basic send with Load and En both high in IDLE
        w = 8'hA5; En = 1'b1; Load = 1'b1; Pin = 8'hA5;
        step;
        Load = 1'b0;
        chk("a5_bit0", Dout, 1'b1);
        chk("a5_frame", Frame, 1'b1);
        chk("a5_ready", Ready, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step;
            chk("a5_bit", Dout, w[i]);
            chk("a5_busy_done", Done, 1'b0);
        end
        end_frame("a5", 1'b0);
        step;
        chk("a5_done_pulse_end", Done, 1'b0);

        // Stall: En low for 4 cycles after bit 2
        w = 8'h3C; frame_cycles = 0; Load = 1'b1; Pin = 8'h3C;
        step;
        Load = 1'b0;
        chk("3c_bit0", Dout, w[0]);
        for (int i = 1; i < 3; i++) begin
            step;
            chk("3c_bit", Dout, w[i]);
        end
        En = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("3c_hold", Dout, 1'b1);
            chk("3c_hold_frame", Frame, 1'b1);
        end
        En = 1'b1;
        for (int i = 3; i < 8; i++) begin
            step;
            chk("3c_bit", Dout, w[i]);
        end
        end_frame("3c", 1'b0);
`ifdef PARITY_EN
        chk("3c_len", (frame_cycles == 13), 1'b1);
`else
        chk("3c_len", (frame_cycles == 12), 1'b1);
`endif

        // Load while busy is ignored
        step;
        w = 8'h01; Load = 1'b1; Pin = 8'h01;
        step;
        Load = 1'b0;
        chk("01_bit0", Dout, 1'b1);
        for (int i = 1; i < 8; i++) begin
            Load = (i == 2 || i == 3); Pin = 8'hFF;
            step;
            chk("01_bit", Dout, w[i]);
        end
        Load = 1'b0;
        end_frame("01", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("01_no_ff_frame", Frame, 1'b0);
            chk("01_no_ff_dout", Dout, 1'b0);
        end

        // Back-to-back with Load held high
        w = 8'h80; Load = 1'b1; Pin = 8'h80;
        step;
        Pin = 8'h01;
        chk("80_bit0", Dout, w[0]);
        for (int i = 1; i < 8; i++) begin
            step;
            chk("80_bit", Dout, w[i]);
        end
        end_frame("80", 1'b1);
        step;
        Load = 1'b0;
        chk("b2b_start_dout", Dout, 1'b1);
        chk("b2b_start_frame", Frame, 1'b1);
        chk("b2b_start_done", Done, 1'b0);
        w = 8'h01;
        for (int i = 1; i < 8; i++) begin
            step;
            chk("b2b_bit", Dout, w[i]);
        end
        end_frame("b2b", 1'b1);

        // Odd-weight word: parity bit 1
        w = 8'h07; Load = 1'b1; Pin = 8'h07;
        step;
        Load = 1'b0;
        chk("07_bit0", Dout, w[0]);
        for (int i = 1; i < 8; i++) begin
            step;
            chk("07_bit", Dout, w[i]);
        end
        end_frame("07", 1'b1);

        // Reset mid-word takes effect without a clock edge
        step;
        Load = 1'b1; Pin = 8'hFF;
        step;
        Load = 1'b0;
        for (int i = 0; i < 3; i++) step;
        chk("ff_pre_rst_frame", Frame, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_rst_dout", Dout, 1'b0);
        chk("mid_rst_ready", Ready, 1'b1);
        chk("mid_rst_frame", Frame, 1'b0);
        chk("mid_rst_done", Done, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step;
            chk("post_rst_no_done", Done, 1'b0);
            chk("post_rst_idle", Frame, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
